// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 key-matrix scanner with whole-frame debounce and ghost (multi-key) rejection.
module keypad_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_TICKS = 2,
  parameter int DEBOUNCE   = 20
) (
  input  logic            clk_1khz,
  input  logic            rst_n,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int TW = SCAN_TICKS > 1 ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;
  state_t state, state_nx;

  logic          active, sample, frame_end, valid_nx;
  logic [RW-1:0] row;
  logic [TW-1:0] tick;
  logic [1:0]    fr_n, s_n, t_n;
  logic [3:0]    fr_code, s_code, t_code, cand, cand_nx, code_nx;
  logic [CW-1:0] cnt, cnt_nx, rel, rel_nx;

  assign sample    = active && tick == TW'(SCAN_TICKS - 1);
  assign frame_end = sample && row == RW'(ROWS - 1);
  assign row_out   = active ? ~(ROWS'(1) << row) : '1;
  assign key_held  = state == HELD;

  // Low-sample count saturates at 2: anything beyond one closure is ghost-prone.
  always_comb begin
    s_n = 2'd0;
    s_code = 4'd0;
    for (int c = 0; c < COLS; c++)
      if (!col_in[c]) begin
        s_n = (s_n == 2'd0) ? 2'd1 : 2'd2;
        s_code = 4'(int'(row) * COLS + c);
      end
    t_n = (fr_n == 2'd0) ? s_n : (s_n == 2'd0) ? fr_n : 2'd2;
    t_code = (fr_n == 2'd0) ? s_code : fr_code;
  end

  always_ff @(posedge clk_1khz or negedge rst_n)
    if (!rst_n) begin
      active  <= 1'b0;
      row     <= '0;
      tick    <= '0;
      fr_n    <= 2'd0;
      fr_code <= 4'd0;
    end else begin
      active <= 1'b1;
      if (active) tick <= sample ? '0 : tick + 1'b1;
      if (sample) begin
        row     <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
        fr_n    <= frame_end ? 2'd0 : t_n;
        fr_code <= frame_end ? 4'd0 : t_code;
      end
    end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rel_nx   = rel;
    cand_nx  = cand;
    code_nx  = key_code;
    valid_nx = 1'b0;
    if (frame_end)
      case (state)
        IDLE:
          if (t_n == 2'd1) begin
            if (DEBOUNCE == 1) begin
              state_nx = HELD;
              code_nx  = t_code;
              valid_nx = 1'b1;
            end else begin
              state_nx = DEB;
              cand_nx  = t_code;
              cnt_nx   = CW'(1);
            end
          end
        DEB:
          if (t_n != 2'd1) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (t_code != cand) begin
            cand_nx = t_code;
            cnt_nx  = CW'(1);
          end else if (cnt + 1'b1 == CW'(DEBOUNCE)) begin
            state_nx = HELD;
            code_nx  = cand;
            valid_nx = 1'b1;
            cnt_nx   = '0;
          end else cnt_nx = cnt + 1'b1;
        HELD:
          if (t_n != 2'd0) rel_nx = '0;
          else if (rel + 1'b1 == CW'(DEBOUNCE)) begin
            state_nx = IDLE;
            rel_nx   = '0;
          end else rel_nx = rel + 1'b1;
        default: state_nx = IDLE;
      endcase
  end

  always_ff @(posedge clk_1khz or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rel       <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rel       <= rel_nx;
      cand      <= cand_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
    end
endmodule
